// File: rtl/mem_access_sequencer_if.sv
// Requester and memory-side signals of the shared instruction/data memory port.
// slave = sequencer side, master = requesters plus memory model.
interface mem_access_sequencer_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic [31:0] mem_addr;
  logic        mem_wr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_ack, if_rdata, d_ack, d_rdata, mem_addr, mem_wr, mem_wdata
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_ack, if_rdata, d_ack, d_rdata, mem_addr, mem_wr, mem_wdata
  );
endinterface

// File: rtl/mem_access_sequencer.sv
// Arbiter/sequencer for the shared memory port: IDLE -> ACCESS (LAT cycles) -> RESP (ack).
// Define MEMSEQ_RR_EN for round-robin arbitration; default is fixed data-over-fetch priority.
module mem_access_sequencer #(
  parameter int unsigned READ_LAT  = 2,
  parameter int unsigned WRITE_LAT = 1
) (
  input  logic                         clock,
  input  logic                         reset,
  mem_access_sequencer_if.slave        bus,
  output logic                         busy,
  output logic [1:0]                   state_out
);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StResp   = 2'd2
  } state_e;

  localparam logic [3:0] ReadCnt  = 4'(READ_LAT - 1);
  localparam logic [3:0] WriteCnt = 4'(WRITE_LAT - 1);

  state_e      state_q;
  logic        owner_d_q;
  logic        we_q;
  logic [3:0]  cnt_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] if_rdata_q;
  logic [31:0] d_rdata_q;
  logic        if_ack_q;
  logic        d_ack_q;
  logic        mem_wr_q;
  logic        grant_d;

`ifdef MEMSEQ_RR_EN
  // Last granted requester; 0 = fetch, so the first conflict goes to data.
  logic last_d_q;

  always_comb begin
    grant_d = bus.d_req;
    if (bus.d_req && bus.if_req) grant_d = ~last_d_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_d_q <= 1'b0;
    end else if (state_q == StIdle && (bus.if_req || bus.d_req)) begin
      last_d_q <= grant_d;
    end
  end
`else
  always_comb begin
    grant_d = bus.d_req;
  end
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      owner_d_q  <= 1'b0;
      we_q       <= 1'b0;
      cnt_q      <= 4'd0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      if_rdata_q <= 32'd0;
      d_rdata_q  <= 32'd0;
      if_ack_q   <= 1'b0;
      d_ack_q    <= 1'b0;
      mem_wr_q   <= 1'b0;
    end else begin
      if_ack_q <= 1'b0;
      d_ack_q  <= 1'b0;
      case (state_q)
        StIdle: begin
          if (bus.if_req || bus.d_req) begin
            owner_d_q <= grant_d;
            we_q      <= grant_d & bus.d_we;
            addr_q    <= grant_d ? bus.d_addr : bus.if_addr;
            if (grant_d) wdata_q <= bus.d_wdata;
            cnt_q     <= (grant_d && bus.d_we) ? WriteCnt : ReadCnt;
            mem_wr_q  <= grant_d & bus.d_we;
            state_q   <= StAccess;
          end
        end
        StAccess: begin
          if (cnt_q == 4'd0) begin
            mem_wr_q <= 1'b0;
            if (!we_q) begin
              if (owner_d_q) d_rdata_q  <= bus.mem_rdata;
              else           if_rdata_q <= bus.mem_rdata;
            end
            if_ack_q <= ~owner_d_q;
            d_ack_q  <= owner_d_q;
            state_q  <= StResp;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StResp: begin
          state_q <= StIdle;
        end
        default: begin
          mem_wr_q <= 1'b0;
          state_q  <= StIdle;
        end
      endcase
    end
  end

  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_wr    = mem_wr_q;
  assign bus.if_ack    = if_ack_q;
  assign bus.d_ack     = d_ack_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign busy          = (state_q == StAccess) || (state_q == StResp);
  assign state_out     = state_q;

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Directed bench: DUT A (READ_LAT=2, WRITE_LAT=1) scoreboarded on acks,
// DUT B (READ_LAT=3) for early request drop, DUT C (READ_LAT=1) for back-to-back fetches.
module tb_mem_access_sequencer;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  mem_access_sequencer_if bus_a ();
  mem_access_sequencer_if bus_b ();
  mem_access_sequencer_if bus_c ();
  logic       busy_a, busy_b, busy_c;
  logic [1:0] st_a, st_b, st_c;

  mem_access_sequencer #(.READ_LAT(2), .WRITE_LAT(1)) u_dut_a (
    .clock(clock), .reset(reset), .bus(bus_a), .busy(busy_a), .state_out(st_a)
  );
  mem_access_sequencer #(.READ_LAT(3), .WRITE_LAT(2)) u_dut_b (
    .clock(clock), .reset(reset), .bus(bus_b), .busy(busy_b), .state_out(st_b)
  );
  mem_access_sequencer #(.READ_LAT(1), .WRITE_LAT(1)) u_dut_c (
    .clock(clock), .reset(reset), .bus(bus_c), .busy(busy_c), .state_out(st_c)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h40) return 32'hDEADBEEF;
    return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  assign bus_a.mem_rdata = mem_word(bus_a.mem_addr);
  assign bus_b.mem_rdata = mem_word(bus_b.mem_addr);
  assign bus_c.mem_rdata = mem_word(bus_c.mem_addr);

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_reset_a();
    check32("rst_mem_addr", bus_a.mem_addr, 32'd0);
    check32("rst_mem_wdata", bus_a.mem_wdata, 32'd0);
    check32("rst_if_rdata", bus_a.if_rdata, 32'd0);
    check32("rst_d_rdata", bus_a.d_rdata, 32'd0);
    check1("rst_mem_wr", bus_a.mem_wr, 1'b0);
    check1("rst_if_ack", bus_a.if_ack, 1'b0);
    check1("rst_d_ack", bus_a.d_ack, 1'b0);
    check1("rst_busy", busy_a, 1'b0);
    check32("rst_state", 32'(st_a), 32'd0);
  endtask

  // Scoreboard for DUT A: one entry per expected ack.
  typedef struct {
    logic        is_d;
    logic [31:0] rdata;
    int          ack_cyc;
  } exp_t;
  exp_t sb_q[$];

  always @(negedge clock) begin
    if (!reset && (bus_a.if_ack || bus_a.d_ack)) begin
      check1("ack_exclusive", bus_a.if_ack & bus_a.d_ack, 1'b0);
      check1("sb_expected_ack", sb_q.size() != 0, 1'b1);
      if (sb_q.size() != 0) begin
        exp_t e;
        e = sb_q.pop_front();
        check1("ack_owner", bus_a.d_ack, e.is_d);
        check32("ack_cycle", 32'(cyc), 32'(e.ack_cyc));
        check32("ack_rdata", e.is_d ? bus_a.d_rdata : bus_a.if_rdata, e.rdata);
      end
    end
  end

  int t;

  initial begin
    reset = 1'b0;
    bus_a.if_req = 0; bus_a.if_addr = 0; bus_a.d_req = 0; bus_a.d_we = 0;
    bus_a.d_addr = 0; bus_a.d_wdata = 0;
    bus_b.if_req = 0; bus_b.if_addr = 0; bus_b.d_req = 0; bus_b.d_we = 0;
    bus_b.d_addr = 0; bus_b.d_wdata = 0;
    bus_c.if_req = 0; bus_c.if_addr = 0; bus_c.d_req = 0; bus_c.d_we = 0;
    bus_c.d_addr = 0; bus_c.d_wdata = 0;
    #1 reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_reset_a();
    tick();
    reset = 1'b0;

    // Fetch read at 0x40; later if_addr changes must not leak into mem_addr.
    t = cyc;
    bus_a.if_req = 1; bus_a.if_addr = 32'h40;
    sb_q.push_back('{is_d: 1'b0, rdata: 32'hDEADBEEF, ack_cyc: t + 3});
    for (int k = 1; k <= 2; k++) begin
      tick();
      bus_a.if_addr = 32'hBAD0_0000;
      @(negedge clock);
      check32("fetch_mem_addr", bus_a.mem_addr, 32'h40);
      check1("fetch_mem_wr", bus_a.mem_wr, 1'b0);
      check1("fetch_busy", busy_a, 1'b1);
    end
    tick();
    bus_a.if_req = 0;
    tick();

    // Simultaneous requests: data first, then fetch (round-robin adds a third data grant).
    t = cyc;
    bus_a.if_req = 1; bus_a.if_addr = 32'h80;
    bus_a.d_req = 1; bus_a.d_we = 0; bus_a.d_addr = 32'h300;
    sb_q.push_back('{is_d: 1'b1, rdata: mem_word(32'h300), ack_cyc: t + 3});
    sb_q.push_back('{is_d: 1'b0, rdata: mem_word(32'h80), ack_cyc: t + 7});
`ifdef MEMSEQ_RR_EN
    sb_q.push_back('{is_d: 1'b1, rdata: mem_word(32'h300), ack_cyc: t + 11});
`endif
    for (int k = 1; k <= 11; k++) begin
      tick();
`ifdef MEMSEQ_RR_EN
      if (k == 11) begin bus_a.if_req = 0; bus_a.d_req = 0; end
`else
      if (k == 3) bus_a.d_req = 0;
      if (k == 7) bus_a.if_req = 0;
`endif
      if (k == 1 || k == 5) begin
        @(negedge clock);
        check32("conflict_mem_addr", bus_a.mem_addr, (k == 1) ? 32'h300 : 32'h80);
      end
    end
    tick();

    // Data write: mem_wr only in t+1, d_rdata keeps the last load value.
    t = cyc;
    bus_a.d_req = 1; bus_a.d_we = 1; bus_a.d_addr = 32'h100; bus_a.d_wdata = 32'h1234;
    sb_q.push_back('{is_d: 1'b1, rdata: mem_word(32'h300), ack_cyc: t + 2});
    tick();
    bus_a.d_req = 0; bus_a.d_we = 0; bus_a.d_addr = 32'hFFFF_0000; bus_a.d_wdata = 32'hFFFF;
    @(negedge clock);
    check1("wr_mem_wr_t1", bus_a.mem_wr, 1'b1);
    check32("wr_mem_addr", bus_a.mem_addr, 32'h100);
    check32("wr_mem_wdata", bus_a.mem_wdata, 32'h1234);
    tick();
    @(negedge clock);
    check1("wr_mem_wr_t2", bus_a.mem_wr, 1'b0);
    check32("wr_state_resp", 32'(st_a), 32'd2);
    tick();

    // Data read at 0x200.
    t = cyc;
    bus_a.d_req = 1; bus_a.d_we = 0; bus_a.d_addr = 32'h200;
    sb_q.push_back('{is_d: 1'b1, rdata: mem_word(32'h200), ack_cyc: t + 3});
    tick();
    bus_a.d_req = 0;
    repeat (3) tick();

    // Reset in the middle of a write: mem_wr drops at once, no ack afterwards.
    bus_a.d_req = 1; bus_a.d_we = 1; bus_a.d_addr = 32'h700; bus_a.d_wdata = 32'h55;
    tick();
    bus_a.d_req = 0; bus_a.d_we = 0;
    @(negedge clock);
    check1("rstwr_mem_wr_before", bus_a.mem_wr, 1'b1);
    reset = 1'b1;
    #1;
    check_reset_a();
    repeat (2) tick();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check1("rstwr_no_d_ack", bus_a.d_ack, 1'b0);
      check1("rstwr_idle", busy_a, 1'b0);
    end
    tick();

    // DUT B: d_req drops after grant, d_addr changes during ACCESS (READ_LAT=3).
    t = cyc;
    bus_b.d_req = 1; bus_b.d_we = 0; bus_b.d_addr = 32'h500;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k == 1) begin bus_b.d_req = 0; bus_b.d_addr = 32'h9999_0000; end
      @(negedge clock);
      if (k <= 3) check32("drop_mem_addr", bus_b.mem_addr, 32'h500);
      check1("drop_d_ack", bus_b.d_ack, k == 4);
      check1("drop_mem_wr", bus_b.mem_wr, 1'b0);
    end
    check32("drop_d_rdata", bus_b.d_rdata, mem_word(32'h500));
    tick();

    // DUT C: held fetch request, READ_LAT=1 -> ack every 3 cycles, one idle cycle between.
    t = cyc;
    bus_c.if_req = 1; bus_c.if_addr = 32'h600;
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (k == 9) bus_c.if_req = 0;
      @(negedge clock);
      check1("b2b_if_ack", bus_c.if_ack, (k % 3) == 2);
      check1("b2b_busy", busy_c, (k % 3) != 0);
      if ((k % 3) == 2) check32("b2b_if_rdata", bus_c.if_rdata, mem_word(32'h600));
    end
    repeat (2) tick();
    @(negedge clock);
    check1("b2b_final_idle", busy_c, 1'b0);

    check32("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
